// File: rtl/wptr_full.sv
// Write-clock-domain half of an asynchronous FIFO. It generates the RAM write address and the
// Gray-coded write pointer, and a pessimistic full / almost-full / fill-count / overflow status.
module wptr_full #(
    parameter int ASIZE     = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2_rptr,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wcount,
    output logic             wovf
);

    localparam logic [ASIZE:0] AFULL_THR = (ASIZE + 1)'(AFULL_LVL);

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ASIZE:0] wbin_q, wbin_d;
    logic [ASIZE:0] wptr_q, wptr_d;
    logic           wfull_q, wfull_d;
    logic           walmost_full_q, walmost_full_d;
    logic [ASIZE:0] wcount_q, wcount_d;
    logic           wovf_q, wovf_d;

    logic           wen;
    logic [ASIZE:0] rbin_s;
    logic [ASIZE:0] fill_s;
    logic [ASIZE:0] rptr_full_s;

    always_comb begin
        // NOTE: every always_comb target is assigned on every path (defaults first), so no latch is inferred.
        wen            = winc & ~wfull_q;
        wbin_d         = wbin_q + {{ASIZE{1'b0}}, wen};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        rbin_s         = gray2bin(wq2_rptr);
        // Modular subtraction keeps the fill level correct across the wrap of either pointer.
        fill_s         = wbin_d - rbin_s;
        // The write pointer is exactly one lap ahead when the two Gray MSBs differ and the rest match.
        rptr_full_s    = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
        wfull_d        = (wptr_d == rptr_full_s);
        wcount_d       = fill_s;
        walmost_full_d = (fill_s >= AFULL_THR);
        wovf_d         = wovf_q;
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wcount_q       <= '0;
            wovf_q         <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wcount_q       <= wcount_d;
            wovf_q         <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ASIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wcount       = wcount_q;
    assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: the driver pushes hand-derived expected post-edge state and
// a monitor pops and compares it one edge later.
module tb_wptr_full;

    localparam int ASIZE = 4;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b1;
    logic       wovf_clr = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wcount;
    logic       wovf;

    always #5 wclk = ~wclk;

    wptr_full #(.ASIZE(ASIZE), .AFULL_LVL(12)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .wovf         (wovf)
    );

    typedef struct {
        string      tag;
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       full;
        logic       af;
        logic [4:0] cnt;
        logic       ovf;
        bit         step_chk;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return (x >> 1) ^ x;
    endfunction

    task automatic vec(input string tag, input logic inc, input logic clr, input logic rst,
                       input logic [4:0] rg, input logic [4:0] ew, input logic [3:0] ea,
                       input logic ef, input logic eaf, input logic [4:0] ec, input logic eo,
                       input bit sc, input int st);
        exp_t e;
        @(negedge wclk);
        winc     = inc;
        wovf_clr = clr;
        wrst     = rst;
        wq2_rptr = rg;
        e.tag = tag; e.wptr = ew; e.waddr = ea; e.full = ef; e.af = eaf;
        e.cnt = ec; e.ovf = eo; e.step_chk = sc; e.step = st;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the registered state one step after each edge.
    exp_t       mon_e;
    logic [4:0] prev_wptr = '0;
    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, ".wptr"},         32'(wptr),         32'(mon_e.wptr));
                check({mon_e.tag, ".waddr"},        32'(waddr),        32'(mon_e.waddr));
                check({mon_e.tag, ".wfull"},        32'(wfull),        32'(mon_e.full));
                check({mon_e.tag, ".walmost_full"}, 32'(walmost_full), 32'(mon_e.af));
                check({mon_e.tag, ".wcount"},       32'(wcount),       32'(mon_e.cnt));
                check({mon_e.tag, ".wovf"},         32'(wovf),         32'(mon_e.ovf));
                if (mon_e.step_chk) begin
                    check({mon_e.tag, ".gray_step"}, 32'($countones(wptr ^ prev_wptr)), 32'(mon_e.step));
                end
            end
            prev_wptr = wptr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    int   m_wbin;
    int   rb;
    int   cnt;
    bit   m_full;
    bit   acc;
    int   hist[$];

    initial begin
        // Reset held two cycles with winc high, then released idle.
        vec("rst0", 1, 0, 1, 5'd0, 5'd0, 4'd0, 0, 0, 5'd0, 0, 0, 0);
        vec("rst1", 1, 0, 1, 5'd0, 5'd0, 4'd0, 0, 0, 5'd0, 0, 0, 0);
        vec("rel",  0, 0, 0, 5'd0, 5'd0, 4'd0, 0, 0, 5'd0, 0, 0, 0);

        // Fill against an idle reader: almost-full at 12, full at 16.
        for (int k = 1; k < 16; k++) begin
            vec($sformatf("fill%0d", k), 1, 0, 0, 5'd0, gray(k), 4'(k), 0, (k >= 12), 5'(k), 0, 0, 0);
        end
        vec("fill16", 1, 0, 0, 5'd0, 5'b11000, 4'd0, 1, 1, 5'd16, 0, 0, 0);

        // Writes at full are dropped and set the sticky overflow; set beats clear.
        for (int i = 0; i < 3; i++) begin
            vec($sformatf("ovf%0d", i), 1, 0, 0, 5'd0, 5'b11000, 4'd0, 1, 1, 5'd16, 1, 0, 0);
        end
        vec("ovf_clr_winc", 1, 1, 0, 5'd0, 5'b11000, 4'd0, 1, 1, 5'd16, 1, 0, 0);
        vec("ovf_clr",      0, 1, 0, 5'd0, 5'b11000, 4'd0, 1, 1, 5'd16, 0, 0, 0);

        // Reader pointer advances to 4: space appears one edge later, then refill.
        vec("release", 0, 0, 0, 5'b00110, 5'b11000, 4'd0, 0, 1, 5'd12, 0, 0, 0);
        vec("refill1", 1, 0, 0, 5'b00110, 5'b11001, 4'd1, 0, 1, 5'd13, 0, 0, 0);
        vec("refill2", 1, 0, 0, 5'b00110, 5'b11011, 4'd2, 0, 1, 5'd14, 0, 0, 0);
        vec("refill3", 1, 0, 0, 5'b00110, 5'b11010, 4'd3, 0, 1, 5'd15, 0, 0, 0);
        vec("refill4", 1, 0, 0, 5'b00110, 5'b11110, 4'd4, 1, 1, 5'd16, 0, 0, 0);
        vec("drain",   0, 0, 0, 5'b11110, 5'b11110, 4'd4, 0, 0, 5'd0,  0, 0, 0);

        // 40 writes with the reader trailing two edges behind; binary pointer wraps 31 -> 0.
        m_wbin = 20;
        m_full = 0;
        hist.push_back(20);
        hist.push_back(20);
        for (int i = 0; i < 40; i++) begin
            rb     = hist.pop_front();
            acc    = !m_full;
            m_wbin = (m_wbin + int'(acc)) % 32;
            cnt    = (m_wbin - rb) & 31;
            m_full = (cnt == 16);
            vec($sformatf("wrap%0d", i), 1, 0, 0, gray(rb), gray(m_wbin), 4'(m_wbin % 16),
                m_full, (cnt >= 12), 5'(cnt), 0, 1, int'(acc));
            hist.push_back(m_wbin);
        end

        // Reset after 7 writes discards the pointer; the next write lands at address 0.
        vec("rst2", 0, 0, 1, 5'd0, 5'd0, 4'd0, 0, 0, 5'd0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            vec($sformatf("mid%0d", k), 1, 0, 0, 5'd0, gray(k), 4'(k), 0, 0, 5'(k), 0, 0, 0);
        end
        vec("rst_mid",  1, 0, 1, 5'd0, 5'd0,     4'd0, 0, 0, 5'd0, 0, 0, 0);
        vec("post_rst", 1, 0, 0, 5'd0, 5'b00001, 4'd1, 0, 0, 5'd1, 0, 0, 0);
        vec("idle",     0, 0, 0, 5'd0, 5'b00001, 4'd1, 0, 0, 5'd1, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge wclk);
        end
        #2;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
